// File: rtl/conv1_frame_ctrl.sv
// conv1_frame_ctrl
//   Sequences one WIDTHxHEIGHT frame through the conv1 datapath. Pixels are
//   read from a synchronous image RAM and streamed back-to-back into conv1,
//   conv1 is held in a local reset between frames, and the conv1 valid
//   outputs are counted and tagged with their output index.
// Ports
//   clk, rst_n        clock / asynchronous active-low reset
//   start, abort      frame start request (IDLE only) / synchronous abort
//   busy, done, err   frame in progress / end-of-frame pulse / sticky error
//   img_rd_en/addr    image RAM read port, img_data returns one cycle later
//   conv_rst_n        registered local reset to conv1 (active low)
//   conv_data/pix_vld pixel stream into conv1
//   conv_valid        conv1 output strobe
//   out_idx/out_cnt   index of the presented output / outputs received
module conv1_frame_ctrl #(
  parameter int WIDTH        = 28,
  parameter int HEIGHT       = 28,
  parameter int KSIZE        = 5,
  parameter int DATA_BITS    = 8,
  parameter int ADDR_BITS    = 10,
  parameter int CLEAR_CYCLES = 2,
  parameter int DRAIN_TMO    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 img_rd_en,
  output logic [ADDR_BITS-1:0] img_addr,
  input  logic [DATA_BITS-1:0] img_data,
  output logic                 conv_rst_n,
  output logic [DATA_BITS-1:0] conv_data,
  output logic                 pix_vld,
  input  logic                 conv_valid,
  output logic [9:0]           out_idx,
  output logic [9:0]           out_cnt
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int NOUT  = (WIDTH - KSIZE + 1) * (HEIGHT - KSIZE + 1);
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int TMO_W = $clog2(DRAIN_TMO + 1);

  localparam logic [ADDR_BITS-1:0] LAST_PIX = ADDR_BITS'(NPIX - 1);
  localparam logic [9:0]           NOUT_C   = 10'(NOUT);
  localparam logic [9:0]           NOUT_M1  = 10'(NOUT - 1);
  localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(DRAIN_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [CLR_W-1:0]     clr_cnt;
  logic [ADDR_BITS-1:0] pix_cnt;
  logic [TMO_W-1:0]     idle_cnt;

  logic start_ok, counting, cnt_ev, cnt_full, reach_nout, tmo_hit, clr_last;

  assign start_ok   = (state == S_IDLE) && start && !abort;
  assign counting   = (state == S_FEED) || (state == S_DRAIN);
  assign cnt_ev     = counting && conv_valid && !abort;
  assign cnt_full   = (out_cnt == NOUT_C);
  // out_cnt equals NOUT after this cycle's update
  assign reach_nout = cnt_full || (cnt_ev && (out_cnt == NOUT_M1));
  // idle_cnt counts cycles since the last valid, that valid cycle included,
  // so done lands DRAIN_TMO cycles after the last valid
  assign tmo_hit    = (state == S_DRAIN) && !conv_valid && (idle_cnt == TMO_LAST);
  assign clr_last   = (clr_cnt == CLR_LAST);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)                   state_nxt = S_CLEAR;
      S_CLEAR: if (clr_last)                state_nxt = S_FEED;
      S_FEED:  if (pix_cnt == LAST_PIX)     state_nxt = S_DRAIN;
      S_DRAIN: if (reach_nout || tmo_hit)   state_nxt = S_DONE;
      S_DONE:                               state_nxt = S_IDLE;
      default:                              state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // outputs decoded from state
  always_comb begin
    busy      = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
    done      = (state == S_DONE);
    // read for pixel k is issued one cycle ahead of FEED cycle k
    img_rd_en = !abort && (((state == S_CLEAR) && clr_last) ||
                           ((state == S_FEED) && (pix_cnt != LAST_PIX)));
    img_addr  = (state == S_FEED) ? pix_cnt + 1'b1 : '0;
  end

  assign conv_data = pix_vld ? img_data : '0;
  assign out_idx   = out_cnt;

  // counters, pipeline and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt    <= '0;
      pix_cnt    <= '0;
      idle_cnt   <= '0;
      out_cnt    <= '0;
      err        <= 1'b0;
      pix_vld    <= 1'b0;
      conv_rst_n <= 1'b0;
    end else begin
      clr_cnt    <= (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;
      pix_cnt    <= (state == S_FEED)  ? pix_cnt + 1'b1 : '0;
      pix_vld    <= img_rd_en;
      conv_rst_n <= (state_nxt == S_FEED) || (state_nxt == S_DRAIN);

      if (start_ok)                   idle_cnt <= '0;
      else if (counting && conv_valid) idle_cnt <= TMO_W'(1);
      else if (state == S_DRAIN)      idle_cnt <= idle_cnt + 1'b1;

      if (start_ok)                 out_cnt <= '0;
      else if (cnt_ev && !cnt_full) out_cnt <= out_cnt + 1'b1;

      if (start_ok)                                          err <= 1'b0;
      else if ((cnt_ev && cnt_full) ||
               (tmo_hit && !reach_nout && !abort))           err <= 1'b1;
    end
  end

endmodule
